// File: rtl/hwpe_stream_tcdm_load_buffer_pkg.sv
// Shared types and helpers for the TCDM load buffer.
package hwpe_stream_tcdm_load_buffer_pkg;

  localparam int unsigned FLAGS_CREDIT_WIDTH = 8;

  // Status bundle that controllers may export from a buffer instance.
  typedef struct packed {
    logic                          empty;
    logic [FLAGS_CREDIT_WIDTH-1:0] credit;
  } flags_tcdm_buffer_t;

  function automatic int unsigned credit_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hwpe_stream_tcdm_resp_fifo.sv
// Plain synchronous response FIFO; flow control is the caller's job.
module hwpe_stream_tcdm_resp_fifo #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  clear_i,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  empty,
  output logic                  full
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [PW:0]           count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (count == '0);
  assign full    = (count == (PW+1)'(DEPTH));
  assign rdata   = empty ? '0 : mem[rptr];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (clear_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/hwpe_stream_tcdm_load_buffer.sv
// TCDM load decoupler: registered request, credit-gated grant, buffered read data.
module hwpe_stream_tcdm_load_buffer
  import hwpe_stream_tcdm_load_buffer_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clear_i,
  input  logic                    slv_req_i,
  output logic                    slv_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   slv_add_i,
  output logic [DATA_WIDTH-1:0]   slv_r_data_o,
  output logic                    slv_r_valid_o,
  input  logic                    slv_r_ready_i,
  output logic                    mst_req_o,
  input  logic                    mst_gnt_i,
  output logic [ADDR_WIDTH-1:0]   mst_add_o,
  output logic                    mst_wen_o,
  output logic [DATA_WIDTH/8-1:0] mst_be_o,
  output logic [DATA_WIDTH-1:0]   mst_data_o,
  input  logic [DATA_WIDTH-1:0]   mst_r_data_i,
  input  logic                    mst_r_valid_i,
  output logic                    empty_o
);

  localparam int unsigned CW = credit_width(FIFO_DEPTH);

  logic                  reg_valid;
  logic [ADDR_WIDTH-1:0] reg_addr;
  logic [CW-1:0]         credit;
  logic                  drop_resp;
  logic                  reg_free;
  logic                  slv_hs;
  logic                  mst_hs;
  logic                  pop;
  logic                  push;
  logic                  fifo_empty;
  logic                  fifo_full;

  // Credit covers register, in-flight and buffered loads, so the FIFO cannot overflow.
  assign reg_free  = !reg_valid || mst_gnt_i;
  assign slv_gnt_o = reg_free && (credit < CW'(FIFO_DEPTH));
  assign slv_hs    = slv_req_i && slv_gnt_o;
  assign mst_hs    = reg_valid && mst_gnt_i;
  assign pop       = slv_r_valid_o && slv_r_ready_i;
  // A response to a request granted during clear belongs to discarded state.
  assign push      = mst_r_valid_i && !drop_resp && !clear_i && !fifo_full;

  assign mst_req_o     = reg_valid;
  assign mst_add_o     = reg_addr;
  assign mst_wen_o     = 1'b1;
  assign mst_be_o      = '1;
  assign mst_data_o    = '0;
  assign slv_r_valid_o = !fifo_empty;
  assign empty_o       = (credit == '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      reg_valid <= 1'b0;
      reg_addr  <= '0;
      drop_resp <= 1'b0;
    end else begin
      drop_resp <= clear_i;
      if (clear_i) begin
        reg_valid <= 1'b0;
        reg_addr  <= '0;
      end else if (slv_hs) begin
        reg_valid <= 1'b1;
        reg_addr  <= slv_add_i;
      end else if (mst_hs) begin
        reg_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      credit <= '0;
    end else if (clear_i) begin
      credit <= '0;
    end else begin
      unique case ({slv_hs, pop})
        2'b10:   credit <= credit + 1'b1;
        2'b01:   credit <= credit - 1'b1;
        default: ;
      endcase
    end
  end

  hwpe_stream_tcdm_resp_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) i_resp_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (clear_i),
    .push    (push),
    .pop     (pop),
    .wdata   (mst_r_data_i),
    .rdata   (slv_r_data_o),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_hwpe_stream_tcdm_load_buffer.sv
// Randomized and directed checks of the load buffer against a queue-based model.
module tb_hwpe_stream_tcdm_load_buffer;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          slv_req_i = 1'b0;
  logic          slv_gnt_o;
  logic [AW-1:0] slv_add_i = '0;
  logic [DW-1:0] slv_r_data_o;
  logic          slv_r_valid_o;
  logic          slv_r_ready_i = 1'b0;
  logic          mst_req_o;
  logic          mst_gnt_i = 1'b0;
  logic [AW-1:0] mst_add_o;
  logic          mst_wen_o;
  logic [DW/8-1:0] mst_be_o;
  logic [DW-1:0] mst_data_o;
  logic [DW-1:0] mst_r_data_i;
  logic          mst_r_valid_i;
  logic          empty_o;

  always #5 clk_i = ~clk_i;

  hwpe_stream_tcdm_load_buffer #(
    .FIFO_DEPTH (DEPTH),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .clear_i       (clear_i),
    .slv_req_i     (slv_req_i),
    .slv_gnt_o     (slv_gnt_o),
    .slv_add_i     (slv_add_i),
    .slv_r_data_o  (slv_r_data_o),
    .slv_r_valid_o (slv_r_valid_o),
    .slv_r_ready_i (slv_r_ready_i),
    .mst_req_o     (mst_req_o),
    .mst_gnt_i     (mst_gnt_i),
    .mst_add_o     (mst_add_o),
    .mst_wen_o     (mst_wen_o),
    .mst_be_o      (mst_be_o),
    .mst_data_o    (mst_data_o),
    .mst_r_data_i  (mst_r_data_i),
    .mst_r_valid_i (mst_r_valid_i),
    .empty_o       (empty_o)
  );

  // Memory: answers every granted request one cycle later with address+0xA000.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mst_r_valid_i <= 1'b0;
      mst_r_data_i  <= '0;
    end else begin
      mst_r_valid_i <= mst_req_o && mst_gnt_i;
      mst_r_data_i  <= (mst_req_o && mst_gnt_i) ? mst_add_o + 32'hA000 : $urandom();
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Model: pending request slot, one load in flight, queue of buffered data.
  logic          m_valid = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic          m_infl = 1'b0;
  logic [AW-1:0] m_infl_addr = '0;
  logic [DW-1:0] m_q[$];

  int            n_hs = 0;
  int            last_hs_cyc = -1;
  int            first_valid = -1;
  logic [DW-1:0] pop_data[$];
  int            pop_cyc[$];
  logic          prev_mhs = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic int outstanding();
    return int'(m_valid) + int'(m_infl) + m_q.size();
  endfunction

  function automatic logic exp_gnt();
    return (!m_valid || mst_gnt_i) && (outstanding() < DEPTH);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_addr  = '0;
    m_infl  = 1'b0;
    m_infl_addr = '0;
    m_q.delete();
  endtask

  task automatic model_step();
    logic pop, hs, mhs;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    pop = (m_q.size() > 0) && slv_r_ready_i;
    hs  = slv_req_i && exp_gnt();
    mhs = m_valid && mst_gnt_i;
    if (clear_i) begin
      model_reset();
    end else begin
      if (pop) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_addr + 32'hA000);
      m_infl = mhs;
      m_infl_addr = m_addr;
      if (hs) begin
        m_valid = 1'b1;
        m_addr  = slv_add_i;
      end else if (mhs) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic monitor();
    if (!rst_ni) begin
      prev_mhs = 1'b0;
      return;
    end
    chk("mst_req", mst_req_o, m_valid);
    chk("mst_add", mst_add_o, m_addr);
    chk("slv_gnt", slv_gnt_o, exp_gnt());
    chk("slv_r_valid", slv_r_valid_o, m_q.size() > 0);
    if (m_q.size() > 0) chk("slv_r_data", slv_r_data_o, m_q[0]);
    chk("empty", empty_o, outstanding() == 0);
    chk("load_ctrl", {mst_wen_o, mst_be_o, mst_data_o}, {1'b1, 4'hF, 32'h0});
    if (mst_r_valid_i) begin
      chk("resp_after_grant", prev_mhs, 1'b1);
      chk("push_not_full", m_q.size() < DEPTH, 1'b1);
    end
    chk("credit_bound", outstanding() <= DEPTH, 1'b1);
    prev_mhs = mst_req_o && mst_gnt_i;
    if (slv_req_i && slv_gnt_o) begin
      n_hs++;
      last_hs_cyc = cyc;
    end
    if (slv_r_valid_o && slv_r_ready_i) begin
      pop_data.push_back(slv_r_data_o);
      pop_cyc.push_back(cyc);
    end
    if (slv_r_valid_o && first_valid < 0) first_valid = cyc;
  endtask

  always @(negedge clk_i) monitor();

  task automatic cycle();
    @(posedge clk_i);
    model_step();
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic load_n(input int n, input logic [AW-1:0] base, input int step);
    int start  = n_hs;
    int target = n_hs + n;
    int guard  = 0;
    while (n_hs < target && guard < 200) begin
      slv_req_i = 1'b1;
      slv_add_i = base + 32'(step * (n_hs - start));
      cycle();
      guard++;
    end
    slv_req_i = 1'b0;
    chk("load_done", n_hs, target);
  endtask

  task automatic clear_logs();
    pop_data.delete();
    pop_cyc.delete();
    first_valid = -1;
  endtask

  initial begin
    int t0, h;
    idle(3);
    rst_ni = 1'b1;
    chk("rst_empty", empty_o, 1'b1);
    chk("rst_r_valid", slv_r_valid_o, 1'b0);
    chk("rst_r_data", slv_r_data_o, 32'h0);
    chk("rst_mst_req", mst_req_o, 1'b0);
    chk("rst_mst_add", mst_add_o, 32'h0);

    // Streaming at full rate
    mst_gnt_i = 1'b1;
    slv_r_ready_i = 1'b1;
    clear_logs();
    t0 = cyc;
    load_n(8, 32'h100, 4);
    idle(6);
    chk("stream_first_beat", first_valid, t0 + 3);
    chk("stream_beats", pop_data.size(), 8);
    for (int i = 0; i < 8; i++) begin
      if (i < pop_data.size()) begin
        chk("stream_data", pop_data[i], 32'hA100 + 32'(4 * i));
        chk("stream_contig", pop_cyc[i], t0 + 3 + i);
      end
    end

    // Credit stall
    slv_r_ready_i = 1'b0;
    clear_logs();
    h = n_hs;
    slv_req_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      slv_add_i = 32'h200 + 32'(4 * i);
      cycle();
    end
    chk("stall_grants", n_hs - h, 4);
    chk("stall_gnt_low", slv_gnt_o, 1'b0);
    slv_r_ready_i = 1'b1;
    cycle();
    slv_r_ready_i = 1'b0;
    chk("stall_one_pop", pop_data.size(), 1);
    for (int i = 0; i < 5; i++) begin
      slv_add_i = 32'h280 + 32'(4 * i);
      cycle();
    end
    chk("stall_one_more", n_hs - h, 5);
    if (pop_cyc.size() > 0) chk("stall_regrant_cycle", last_hs_cyc, pop_cyc[0] + 1);
    slv_req_i = 1'b0;
    slv_r_ready_i = 1'b1;
    idle(8);

    // Grant stall
    mst_gnt_i = 1'b0;
    clear_logs();
    h = n_hs;
    slv_req_i = 1'b1;
    slv_add_i = 32'h300;
    cycle();
    for (int i = 0; i < 5; i++) begin
      slv_add_i = 32'h400 + 32'(4 * i);
      cycle();
      chk("gstall_req", mst_req_o, 1'b1);
      chk("gstall_add", mst_add_o, 32'h300);
      chk("gstall_gnt", slv_gnt_o, 1'b0);
    end
    mst_gnt_i = 1'b1;
    slv_req_i = 1'b0;
    idle(5);
    chk("gstall_grants", n_hs - h, 1);
    chk("gstall_pops", pop_data.size(), 1);
    if (pop_data.size() > 0) chk("gstall_data", pop_data[0], 32'hA300);

    // Push and pop together with two entries buffered
    slv_r_ready_i = 1'b0;
    load_n(2, 32'h500, 4);
    idle(3);
    slv_r_ready_i = 1'b1;
    slv_req_i = 1'b1;
    for (int i = 0; i < 12; i++) begin
      slv_add_i = 32'h540 + 32'(4 * i);
      cycle();
    end
    slv_req_i = 1'b0;
    idle(8);
    chk("simul_drained", empty_o, 1'b1);

    // Clear with loads outstanding and a response arriving just after
    slv_r_ready_i = 1'b0;
    load_n(3, 32'h600, 4);
    clear_i = 1'b1;
    cycle();
    clear_i = 1'b0;
    chk("clr_resp_arrives", mst_r_valid_i, 1'b1);
    chk("clr_empty", empty_o, 1'b1);
    chk("clr_valid", slv_r_valid_o, 1'b0);
    chk("clr_mst_req", mst_req_o, 1'b0);
    cycle();
    chk("clr_dropped_valid", slv_r_valid_o, 1'b0);
    chk("clr_dropped_empty", empty_o, 1'b1);
    chk("clr_data", slv_r_data_o, 32'h0);

    // Asynchronous reset mid-transfer
    slv_r_ready_i = 1'b1;
    load_n(3, 32'h700, 4);
    #2;
    rst_ni = 1'b0;
    model_reset();
    #1;
    chk("arst_mst_req", mst_req_o, 1'b0);
    chk("arst_mst_add", mst_add_o, 32'h0);
    chk("arst_r_valid", slv_r_valid_o, 1'b0);
    chk("arst_r_data", slv_r_data_o, 32'h0);
    chk("arst_empty", empty_o, 1'b1);
    idle(2);
    rst_ni = 1'b1;
    clear_logs();
    load_n(2, 32'h800, 4);
    idle(6);
    chk("arst_pops", pop_data.size(), 2);
    if (pop_data.size() == 2) begin
      chk("arst_data0", pop_data[0], 32'hA800);
      chk("arst_data1", pop_data[1], 32'hA804);
    end

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      slv_req_i     = ($urandom_range(3) != 0);
      slv_add_i     = $urandom() & 32'hFFFF_FFFC;
      mst_gnt_i     = ($urandom_range(2) != 0);
      slv_r_ready_i = ($urandom_range(3) != 0);
      clear_i       = ($urandom_range(63) == 0);
      cycle();
    end
    slv_req_i = 1'b0;
    clear_i = 1'b0;
    mst_gnt_i = 1'b1;
    slv_r_ready_i = 1'b1;
    idle(10);
    chk("final_empty", empty_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
